// File: rtl/mac4_dot_seq_pkg.sv
// Shared types and default widths for the 4-lane MAC dot-product sequencer.
package mac4_dot_seq_pkg;

   localparam int MAC_LANES    = 4;
   localparam int FEAT_WIDTH   = 8;
   localparam int WGT_WIDTH    = 8;
   localparam int PE_OUT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/mac4_dot_seq.sv
// Dot-product sequencer: streams operand groups into an external 4-lane MAC,
// frames the accumulate control, and returns the final sum on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; len sampled with start
// RUN   | accepting groups; first beat clears the MAC accumulator
// DRAIN | MAC output now holds the final sum; capture it
// DONE  | result presented until res_ready
module mac4_dot_seq
   import mac4_dot_seq_pkg::*;
#(
   parameter int FEAT_WIDTH   = mac4_dot_seq_pkg::FEAT_WIDTH,
   parameter int WGT_WIDTH    = mac4_dot_seq_pkg::WGT_WIDTH,
   parameter int PE_OUT_WIDTH = mac4_dot_seq_pkg::PE_OUT_WIDTH,
   parameter int LEN_WIDTH    = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [LEN_WIDTH-1:0]            len,
   output logic                            busy,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [MAC_LANES*FEAT_WIDTH-1:0] in_a,
   input  logic [MAC_LANES*WGT_WIDTH-1:0]  in_b,
   output logic                            mac_acc,
   output logic [MAC_LANES*FEAT_WIDTH-1:0] mac_a,
   output logic [MAC_LANES*WGT_WIDTH-1:0]  mac_b,
   input  logic [PE_OUT_WIDTH-1:0]         mac_sum,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [PE_OUT_WIDTH-1:0]         res_data
);

   seq_state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0]     count_q, count_d;
   logic                     first_q, first_d;
   logic [PE_OUT_WIDTH-1:0]  res_data_q, res_data_d;
   logic                     fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         first_q    <= 1'b1;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         first_q    <= first_d;
         res_data_q <= res_data_d;
      end
   end

   assign in_ready = (state_q == RUN);
   assign fire     = in_valid & in_ready;

   // Idle beats drive zero products with acc=1 so the MAC holds its sum.
   always_comb begin
      mac_a   = '0;
      mac_b   = '0;
      mac_acc = 1'b1;
      if (fire) begin
         mac_a   = in_a;
         mac_b   = in_b;
         mac_acc = ~first_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      first_d    = first_q;
      res_data_d = res_data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  count_d = len;
                  first_d = 1'b1;
                  state_d = RUN;
               end else begin
                  res_data_d = '0;
                  state_d    = DONE;
               end
            end
         end
         RUN: begin
            if (fire) begin
               first_d = 1'b0;
               count_d = count_q - 1'b1;
               if (count_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) state_d = DRAIN;
            end
         end
         DRAIN: begin
            res_data_d = mac_sum;
            state_d    = DONE;
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == DONE);
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac4_dot_seq.sv
// Bench for mac4_dot_seq: a behavioural MAC drives mac_sum, a transaction-level
// model predicts handshakes and results, and directed jobs pin the model.
`timescale 1ns/1ps
module tb_mac4_dot_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        busy;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        mac_acc;
   logic [31:0] mac_a;
   logic [31:0] mac_b;
   logic [15:0] mac_sum = 16'hDEAD;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [31:0] ga [4];
   logic [31:0] gb [4];

   mac4_dot_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_acc(mac_acc), .mac_a(mac_a), .mac_b(mac_b), .mac_sum(mac_sum),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
      int s = 0;
      for (int k = 0; k < 4; k++) s += int'(a[k*8 +: 8]) * int'(b[k*8 +: 8]);
      return s;
   endfunction

   function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
      logic [31:0] v;
      v = {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
      return v;
   endfunction

   // Behavioural MAC: no reset, no enable, one-cycle registered latency.
   always @(posedge clk) begin
      logic [31:0] p;
      p = dot4(mac_a, mac_b);
      mac_sum <= p[15:0] + (mac_acc ? mac_sum : 16'd0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: 0 idle, 1 accepting, 2 draining, 3 presenting.
   int          m_mode = 0;
   int          m_left = 0;
   bit          m_first = 1'b1;
   int          m_sum = 0;
   logic [15:0] m_res = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_mode = 0; m_left = 0; m_first = 1'b1; m_res = '0;
         end
         check("busy", busy, m_mode != 0);
         check("in_ready", in_ready, m_mode == 1);
         check("res_valid", res_valid, m_mode == 3);
         if (m_mode == 3 || !rst_n) check("res_data", res_data, m_res);
         if (m_mode == 1 && in_valid) begin
            check("mac_a", mac_a, in_a);
            check("mac_b", mac_b, in_b);
            check("mac_acc", mac_acc, !m_first);
         end else begin
            check("mac_a_idle", mac_a, 0);
            check("mac_b_idle", mac_b, 0);
            check("mac_acc_idle", mac_acc, 1);
         end
         if (rst_n) begin
            case (m_mode)
               0: if (start) begin
                     if (len != 0) begin
                        m_mode = 1; m_left = len; m_first = 1'b1; m_sum = 0;
                     end else begin
                        m_mode = 3; m_res = '0;
                     end
                  end
               1: if (in_valid) begin
                     m_sum = (m_sum + dot4(in_a, in_b)) % 65536;
                     m_first = 1'b0;
                     m_left--;
                     if (m_left == 0) m_mode = 2;
                  end
               2: begin m_res = m_sum[15:0]; m_mode = 3; end
               default: if (res_ready) m_mode = 0;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int n, input int gap, input int hold, input bit poke_start,
                          output logic [15:0] res, output int lat);
      int w;
      int fire_edge;
      start = 1'b1; len = n[7:0];
      tick();
      start = 1'b0; len = '0;
      fire_edge = cyc;
      for (int i = 0; i < n; i++) begin
         if (i > 0) repeat (gap) tick();
         in_valid = 1'b1; in_a = ga[i]; in_b = gb[i];
         w = 0;
         while (!in_ready && w < 20) begin tick(); w++; end
         if (w >= 20) check("in_ready_timeout", 0, 1);
         tick();
         fire_edge = cyc;
         in_valid = 1'b0; in_a = '0; in_b = '0;
      end
      w = 0;
      while (!res_valid && w < 20) begin tick(); w++; end
      if (w >= 20) check("res_valid_timeout", 0, 1);
      lat = cyc - fire_edge + 1;
      res = res_data;
      for (int h = 0; h < hold; h++) begin
         if (poke_start && h == 1) begin start = 1'b1; len = 8'd5; end
         tick();
         start = 1'b0; len = '0;
         check("res_hold_stable", res_data, res);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("idle_after_ack", busy, 0);
   endtask

   initial begin
      logic [15:0] r;
      int lat;
      repeat (2) tick();
      check("reset_busy", busy, 0);
      check("reset_res_valid", res_valid, 0);
      check("reset_res_data", res_data, 0);
      check("reset_in_ready", in_ready, 0);
      rst_n = 1'b1;
      tick();

      ga[0] = pack4(1, 2, 3, 4); gb[0] = pack4(5, 6, 7, 8);
      run_job(1, 0, 0, 1'b0, r, lat);
      check("len1_result", r, 70);
      check("len1_latency", lat, 2);

      ga[1] = pack4(1, 1, 1, 1); gb[1] = pack4(1, 1, 1, 1);
      run_job(2, 0, 0, 1'b0, r, lat);
      check("len2_result", r, 74);
      check("len2_latency", lat, 2);

      run_job(2, 3, 0, 1'b0, r, lat);
      check("gap_result", r, 74);

      run_job(0, 0, 0, 1'b0, r, lat);
      check("len0_result", r, 0);
      check("len0_latency", lat, 1);

      ga[0] = pack4(255, 255, 255, 255); gb[0] = ga[0];
      ga[1] = ga[0]; gb[1] = ga[0];
      run_job(2, 0, 0, 1'b0, r, lat);
      check("wrap_result", r, 61448);

      ga[0] = pack4(1, 2, 3, 4); gb[0] = pack4(5, 6, 7, 8);
      run_job(1, 0, 3, 1'b1, r, lat);
      check("stall_result", r, 70);

      // Abort a len=3 job after its first group, then rerun a clean job.
      start = 1'b1; len = 8'd3;
      tick();
      start = 1'b0; len = '0;
      in_valid = 1'b1; in_a = pack4(9, 9, 9, 9); in_b = pack4(9, 9, 9, 9);
      tick();
      in_valid = 1'b0; in_a = '0; in_b = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      check("abort_busy", busy, 0);
      check("abort_res_valid", res_valid, 0);
      rst_n = 1'b1;
      tick();
      run_job(1, 0, 0, 1'b0, r, lat);
      check("post_reset_result", r, 70);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
